// File: rtl/scan_decoder.sv
// scan_decoder -- registered N-to-2^N decoder with a valid/ready input handshake.
//
// It drives select or enable lines (LED banks, chip selects, mux strobes) from a
// narrow index bus. There are four modes:
//   00 one-hot             y[i] = (i == sel)
//   01 thermometer         y[i] = (i <= sel)
//   10 auto-scan           a one-hot bit walks upward from sel and stays
//                          dwell+1 cycles at each position
//   11 active-low one-hot  y[i] = (i != sel)
//
// Handshake: in_ready = en, and it is combinational. A transfer (accept) happens
// on a rising edge where in_valid & in_ready are both high. On an accept the block
// captures sel, mode and dwell, and y/y_valid show the result one cycle later.
// The block can accept every cycle, and the newest accept always wins. Inputs
// presented without an accept are ignored.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   en                block enable; low forces IDLE on the next edge and
//                     takes priority over in_valid
//   in_valid/in_ready input handshake
//   sel, mode, dwell  decode index / scan start, mode select, scan dwell
//   y, y_valid        registered decoded output and its qualifier
//   scan_wrap         one-cycle pulse on the edge where a scan wraps to bit 0
//   state_dbg         current FSM state (0 IDLE, 1 HOLD, 2 SCAN)
module scan_decoder #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       sel,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<IN_W)-1:0]  y,
  output logic                  y_valid,
  output logic                  scan_wrap,
  output logic [1:0]            state_dbg
);

  localparam int OUT_W = 1 << IN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [OUT_W-1:0]     y_q, y_n;
  logic                 vld_q, vld_n;
  logic                 wrap_q, wrap_n;
  logic [IN_W-1:0]      pos_q, pos_n;
  logic [DWELL_W-1:0]   cnt_q, cnt_n;
  logic [DWELL_W-1:0]   dwell_q, dwell_n;
  logic                 accept;

  function automatic logic [OUT_W-1:0] decode(input logic [1:0] m,
                                              input logic [IN_W-1:0] s);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (m)
        2'b01:   r[i] = (i <= int'(s));
        2'b11:   r[i] = (i != int'(s));
        default: r[i] = (i == int'(s));
      endcase
    end
    return r;
  endfunction

  assign in_ready  = en;
  assign accept    = in_valid & en;
  assign y         = y_q;
  assign y_valid   = vld_q;
  assign scan_wrap = wrap_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_n;
      y_q     <= y_n;
      vld_q   <= vld_n;
      wrap_q  <= wrap_n;
      pos_q   <= pos_n;
      cnt_q   <= cnt_n;
      dwell_q <= dwell_n;
    end
  end

  always_comb begin
    state_n = state_q;
    y_n     = y_q;
    vld_n   = vld_q;
    wrap_n  = 1'b0;
    pos_n   = pos_q;
    cnt_n   = cnt_q;
    dwell_n = dwell_q;

    if (!en) begin
      state_n = IDLE;
      y_n     = '0;
      vld_n   = 1'b0;
      cnt_n   = '0;
    end else if (accept) begin
      vld_n = 1'b1;
      cnt_n = '0;
      if (mode == 2'b10) begin
        // The first scan position is sel itself and never pulses scan_wrap.
        state_n = SCAN;
        pos_n   = sel;
        dwell_n = dwell;
        y_n     = decode(2'b00, sel);
      end else begin
        state_n = HOLD;
        y_n     = decode(mode, sel);
      end
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_q == dwell_q) begin
            cnt_n  = '0;
            // pos is IN_W bits wide, so OUT_W-1 rolls over to 0 naturally.
            pos_n  = pos_q + 1'b1;
            y_n    = decode(2'b00, pos_n);
            wrap_n = (pos_q == {IN_W{1'b1}});
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        HOLD:    state_n = HOLD;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder. It runs a table of single-cycle decode
// vectors, hand-written multi-cycle scan, enable and reset sequences, and a
// randomized phase checked against an arithmetic reference model.
module tb_scan_decoder;

  localparam int IN_W    = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    sel;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic               y_valid;
  logic               scan_wrap;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected {scan_wrap, y_valid, y} after each edge.
  logic [OUT_W+1:0] exp_q[$];

  // Reference model state: the last captured request and the number of edges since it.
  bit       m_act;
  int       m_mode, m_sel, m_dwell, m_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  scan_decoder #(.IN_W(IN_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .dwell(dwell), .y(y), .y_valid(y_valid),
    .scan_wrap(scan_wrap), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [2:0] sel;
    logic [1:0] mode;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[13];

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic [2:0] s,
                       input logic [1:0] m, input logic [7:0] d);
    en = e; in_valid = v; sel = s; mode = m; dwell = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Called with the inputs that will be sampled on the coming edge.
  task automatic model_edge(input logic e, input logic v, input logic [2:0] s,
                            input logic [1:0] m, input logic [7:0] d);
    if (!e) begin
      m_act = 0;
    end else if (v) begin
      m_act = 1; m_mode = int'(m); m_sel = int'(s); m_dwell = int'(d); m_t = 0;
    end else if (m_act) begin
      m_t++;
    end
  endtask

  function automatic logic [OUT_W+1:0] model_out();
    logic [7:0] yy;
    logic       w;
    int         p;
    if (!m_act) return '0;
    w = 1'b0;
    case (m_mode)
      0:       yy = 8'(1 << m_sel);
      1:       yy = 8'((2 << m_sel) - 1);
      3:       yy = ~8'(1 << m_sel);
      default: begin
        p  = (m_sel + m_t / (m_dwell + 1)) % OUT_W;
        yy = 8'(1 << p);
        w  = (m_t > 0) && (m_t % (m_dwell + 1) == 0) && (p == 0);
      end
    endcase
    return {w, 1'b1, yy};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = '{3'd0, 2'b00, 8'h01};
    vecs[1]  = '{3'd1, 2'b00, 8'h02};
    vecs[2]  = '{3'd2, 2'b00, 8'h04};
    vecs[3]  = '{3'd3, 2'b00, 8'h08};
    vecs[4]  = '{3'd4, 2'b00, 8'h10};
    vecs[5]  = '{3'd5, 2'b00, 8'h20};
    vecs[6]  = '{3'd6, 2'b00, 8'h40};
    vecs[7]  = '{3'd7, 2'b00, 8'h80};
    vecs[8]  = '{3'd3, 2'b01, 8'h0F};
    vecs[9]  = '{3'd7, 2'b01, 8'hFF};
    vecs[10] = '{3'd0, 2'b01, 8'h01};
    vecs[11] = '{3'd5, 2'b11, 8'hDF};
    vecs[12] = '{3'd5, 2'b00, 8'h20};

    // Reset takes effect before any clock edge.
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 2'b00, 8'd0);
    #1;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_y_valid", 32'(y_valid), 32'h0);
    chk("reset_wrap", 32'(scan_wrap), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Back-to-back decode vectors; each result appears one edge after its accept.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b1, vecs[i].sel, vecs[i].mode, 8'd0);
      tick();
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d_valid", i), 32'(y_valid), 32'h1);
    end

    // Scan from 6 with dwell 2, wrapping to bit 0.
    drive(1'b1, 1'b1, 3'd6, 2'b10, 8'd2);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan6_y%0d", k), 32'(y), (k < 3) ? 32'h40 : (k < 6) ? 32'h80 : 32'h01);
      chk($sformatf("scan6_wrap%0d", k), 32'(scan_wrap), (k == 6) ? 32'h1 : 32'h0);
      tick();
    end

    // Scan from 0 with dwell 0: no pulse at the start, a pulse on the real wrap.
    drive(1'b1, 1'b1, 3'd0, 2'b10, 8'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("scan0_y%0d", k), 32'(y), 32'(1 << (k % 8)));
      chk($sformatf("scan0_wrap%0d", k), 32'(scan_wrap), (k == 8) ? 32'h1 : 32'h0);
      if (k < 9) tick();
    end
    drive(1'b1, 1'b1, 3'd2, 2'b00, 8'd0);
    tick();
    chk("midscan_y", 32'(y), 32'h04);
    in_valid = 1'b0;
    tick();
    chk("scan_stopped_y", 32'(y), 32'h04);
    chk("scan_stopped_wrap", 32'(scan_wrap), 32'h0);

    // Enable low in HOLD: in_ready drops at once, outputs clear on the next edge.
    drive(1'b0, 1'b1, 3'd4, 2'b00, 8'd0);
    #1;
    chk("en_low_ready", 32'(in_ready), 32'h0);
    tick();
    chk("en_low_y", 32'(y), 32'h0);
    chk("en_low_valid", 32'(y_valid), 32'h0);
    chk("en_low_state", 32'(state_dbg), 32'h0);

    // Reset asserted between edges, just after a wrap pulse.
    drive(1'b1, 1'b1, 3'd7, 2'b10, 8'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_wrap", 32'(scan_wrap), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_y", 32'(y), 32'h0);
    chk("rst_mid_wrap", 32'(scan_wrap), 32'h0);
    chk("rst_mid_valid", 32'(y_valid), 32'h0);
    #1 rst = 1'b0;

    // A dwell of all ones gives 256 cycles per position.
    drive(1'b1, 1'b1, 3'd3, 2'b10, 8'hFF);
    tick();
    in_valid = 1'b0;
    repeat (255) tick();
    chk("dwell_max_hold", 32'(y), 32'h08);
    tick();
    chk("dwell_max_step", 32'(y), 32'h10);

    // Randomized phase against the reference model.
    drive(1'b0, 1'b0, 3'd0, 2'b00, 8'd0);
    tick();
    m_act = 0; m_t = 0;
    for (int c = 0; c < 2000; c++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3)));
      #1;
      chk("rand_ready", 32'(in_ready), 32'(en));
      model_edge(en, in_valid, sel, mode, dwell);
      exp_q.push_back(model_out());
      tick();
      chk($sformatf("rand_out_c%0d", c), 32'({scan_wrap, y_valid, y}), 32'(exp_q.pop_front()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
